// File: rtl/morse_rx_decoder_gen.sv
// Morse receive decoder: manual three-key or single-key timed entry, 6-bit character codes,
// NUM_CHARS-deep shifting display buffer with backspace, error and per-character strobe.
module morse_rx_decoder_gen #(
  parameter int unsigned NUM_CHARS  = 8,
  parameter int unsigned DASH_TICKS = 6000000,
  parameter int unsigned GAP_TICKS  = 15000000,
  parameter int unsigned CNT_W      = 24
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iEnable,
  input  logic                   iMode,
  input  logic                   iKeyDash,
  input  logic                   iKeyDot,
  input  logic                   iKeyConfirm,
  input  logic                   iKeyBack,
  output logic [6*NUM_CHARS-1:0] oDisplayData,
  output logic [5:0]             oChar,
  output logic                   oCharValid,
  output logic                   oError,
  output logic [2:0]             oPending,
  output logic                   oBuzzer
);

  localparam int unsigned    BufW      = 6 * NUM_CHARS;
  localparam logic [5:0]     CodeErr   = 6'd62;
  localparam logic [5:0]     CodeBlank = 6'd63;
  localparam logic [CNT_W-1:0] DashCnt = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  state_e            state_q, state_d;
  logic [3:0]        key_q;            // {back, confirm, dash, dot}, 1 = released
  logic              mode_q, mode_d;
  logic [4:0]        stack_q, stack_d;
  logic [2:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic [5:0]        char_q, char_d;
  logic              valid_q, valid_d;
  logic              error_q, error_d;

  logic [3:0] key_now, ev;
  logic       ev_dot, ev_dash, ev_conf, ev_back, mode_chg;
  logic       clr_pend, push, push_sym, commit, back_shift;
  logic [5:0] code;

  assign key_now  = {iKeyBack, iKeyConfirm, iKeyDash, iKeyDot};
  assign ev       = {4{iEnable}} & key_q & ~key_now;
  assign ev_dot   = ev[0];
  assign ev_dash  = ev[1];
  assign ev_conf  = ev[2];
  assign ev_back  = ev[3];
  assign mode_chg = iMode != mode_q;

  // First symbol sits in the most significant used bit; dash = 1.
  function automatic logic [5:0] decode(input logic [2:0] cnt, input logic [4:0] stk,
                                        input logic ovf);
    logic [5:0] c;
    c = CodeErr;
    if (!ovf) begin
      case (cnt)
        3'd0: c = CodeBlank;
        3'd1: c = stk[0] ? 6'd19 : 6'd4;
        3'd2: begin
          case (stk[1:0])
            2'b01:   c = 6'd0;
            2'b11:   c = 6'd12;
            2'b10:   c = 6'd13;
            default: c = 6'd8;
          endcase
        end
        3'd3: begin
          case (stk[2:0])
            3'b100:  c = 6'd3;
            3'b110:  c = 6'd6;
            3'b101:  c = 6'd10;
            3'b111:  c = 6'd14;
            3'b010:  c = 6'd17;
            3'b000:  c = 6'd18;
            3'b001:  c = 6'd20;
            default: c = 6'd22;
          endcase
        end
        3'd4: begin
          case (stk[3:0])
            4'b1000: c = 6'd1;
            4'b1010: c = 6'd2;
            4'b0010: c = 6'd5;
            4'b0000: c = 6'd7;
            4'b0111: c = 6'd9;
            4'b0100: c = 6'd11;
            4'b0110: c = 6'd15;
            4'b1101: c = 6'd16;
            4'b0001: c = 6'd21;
            4'b1001: c = 6'd23;
            4'b1011: c = 6'd24;
            4'b1100: c = 6'd25;
            default: c = CodeErr;
          endcase
        end
        3'd5: begin
          case (stk)
            5'b11111: c = 6'd26;
            5'b01111: c = 6'd27;
            5'b00111: c = 6'd28;
            5'b00011: c = 6'd29;
            5'b00001: c = 6'd30;
            5'b00000: c = 6'd31;
            5'b10000: c = 6'd32;
            5'b11000: c = 6'd33;
            5'b11100: c = 6'd34;
            5'b11110: c = 6'd35;
            default:  c = CodeErr;
          endcase
        end
        default: c = CodeErr;
      endcase
    end
    return c;
  endfunction

  // FSM next state; manual mode never leaves StIdle.
  always_comb begin
    state_d = state_q;
    if (iEnable) begin
      if (mode_chg || ev_back || ev_conf || !iMode) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle:  if (ev_dot) state_d = StPress;
          StPress: if (iKeyDot) state_d = StGap;
          StGap: begin
            if (ev_dot) state_d = StPress;
            else if (gap_cnt_q >= GapLast) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // FSM outputs: event actions and timing counters, Back > Confirm > Dash > Dot.
  always_comb begin
    clr_pend    = 1'b0;
    push        = 1'b0;
    push_sym    = 1'b0;
    commit      = 1'b0;
    back_shift  = 1'b0;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (iEnable) begin
      if (mode_chg || ev_back || ev_conf) begin
        press_cnt_d = '0;
        gap_cnt_d   = '0;
        if (mode_chg) clr_pend = 1'b1;
        else if (ev_back) begin
          if (count_q != 3'd0) clr_pend = 1'b1;
          else back_shift = 1'b1;
        end else commit = 1'b1;
      end else if (!iMode) begin
        if (ev_dash) begin
          push     = 1'b1;
          push_sym = 1'b1;
        end else if (ev_dot) begin
          push = 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (ev_dot) begin
              press_cnt_d = CNT_W'(1);
              gap_cnt_d   = '0;
            end
          end
          StPress: begin
            if (iKeyDot) begin
              push        = 1'b1;
              push_sym    = press_cnt_q >= DashCnt;
              press_cnt_d = '0;
              gap_cnt_d   = '0;
            end else if (press_cnt_q < DashCnt) begin
              press_cnt_d = press_cnt_q + CNT_W'(1);
            end
          end
          StGap: begin
            if (ev_dot) begin
              press_cnt_d = CNT_W'(1);
              gap_cnt_d   = '0;
            end else if (gap_cnt_q >= GapLast) begin
              commit    = 1'b1;
              gap_cnt_d = '0;
            end else begin
              gap_cnt_d = gap_cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign code = decode(count_q, stack_q, ovf_q);

  always_comb begin
    mode_d  = iEnable ? iMode : mode_q;
    stack_d = stack_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    buf_d   = buf_q;
    char_d  = char_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (clr_pend || commit) begin
      stack_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end
    if (push) begin
      if (count_q == 3'd5) begin
        ovf_d = 1'b1;
      end else begin
        stack_d = {stack_q[3:0], push_sym};
        count_d = count_q + 3'd1;
      end
    end
    if (commit) begin
      buf_d   = {buf_q[BufW-7:0], code};
      char_d  = code;
      valid_d = 1'b1;
      error_d = code == CodeErr;
    end
    if (back_shift) buf_d = {CodeBlank, buf_q[BufW-1:6]};
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= StIdle;
      key_q       <= 4'hF;
      mode_q      <= 1'b0;
      stack_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      buf_q       <= '1;
      char_q      <= CodeBlank;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_now;
      mode_q      <= mode_d;
      stack_q     <= stack_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      buf_q       <= buf_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
    end
  end

  assign oDisplayData = buf_q;
  assign oChar        = char_q;
  assign oCharValid   = valid_q;
  assign oError       = error_q;
  assign oPending     = count_q;
  assign oBuzzer      = iEnable & (~iKeyDot | (~iMode & ~iKeyDash));

endmodule

// File: tb/tb_morse_rx_decoder_gen.sv
// Directed bench for morse_rx_decoder_gen; committed characters are matched against a
// scoreboard queue filled when the commit stimulus is driven.
module tb_morse_rx_decoder_gen;

  localparam int unsigned NC = 8;
  localparam int unsigned W  = 6 * NC;
  localparam int KDot = 0, KDash = 1, KConf = 2, KBack = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b1, mode = 1'b0;
  logic k_dash = 1'b1, k_dot = 1'b1, k_conf = 1'b1, k_back = 1'b1;

  logic [W-1:0] disp;
  logic [5:0]   ochar;
  logic         ovalid, oerr, obuz;
  logic [2:0]   pend;

  morse_rx_decoder_gen #(
    .NUM_CHARS (NC),
    .DASH_TICKS(4),
    .GAP_TICKS (8),
    .CNT_W     (24)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iEnable     (en),
    .iMode       (mode),
    .iKeyDash    (k_dash),
    .iKeyDot     (k_dot),
    .iKeyConfirm (k_conf),
    .iKeyBack    (k_back),
    .oDisplayData(disp),
    .oChar       (ochar),
    .oCharValid  (ovalid),
    .oError      (oerr),
    .oPending    (pend),
    .oBuzzer     (obuz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]   code;
    logic         err;
    logic [W-1:0] disp;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] model_buf = '1;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, return just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (ovalid) begin
        if (sb_q.size() == 0) chk("unexpected_strobe", 64'(ovalid), 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("char", 64'(ochar), 64'(e.code));
          chk("error", 64'(oerr), 64'(e.err));
          chk("display", 64'(disp), 64'(e.disp));
        end
      end else begin
        chk("error_without_strobe", 64'(oerr), 64'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      KDot:    k_dot = v;
      KDash:   k_dash = v;
      KConf:   k_conf = v;
      default: k_back = v;
    endcase
  endtask

  task automatic tap(input int k);
    set_key(k, 1'b0);
    tick();
    set_key(k, 1'b1);
    tick();
  endtask

  task automatic expect_commit(input logic [5:0] code);
    exp_t e;
    model_buf = {model_buf[W-7:0], code};
    e.code = code;
    e.err  = code == 6'd62;
    e.disp = model_buf;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    chk({"drain_", tag}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic commit(input logic [5:0] code, input string tag);
    expect_commit(code);
    tap(KConf);
    drain(tag, 4);
  endtask

  task automatic press_t(input int n);
    k_dot = 1'b0;
    repeat (n) tick();
    k_dot = 1'b1;
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_disp"}, 64'(disp), {{(64 - W){1'b0}}, {W{1'b1}}});
    chk({tag, "_char"}, 64'(ochar), 64'd63);
    chk({tag, "_valid"}, 64'(ovalid), 64'd0);
    chk({tag, "_error"}, 64'(oerr), 64'd0);
    chk({tag, "_pending"}, 64'(pend), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Manual A
    tap(KDot);
    tap(KDash);
    chk("pending_A", 64'(pend), 64'd2);
    commit(6'd0, "A");
    chk("pending_after_A", 64'(pend), 64'd0);

    // Digit '1', then overflow -> error
    tap(KDot);
    repeat (4) tap(KDash);
    commit(6'd27, "digit1");
    repeat (5) tap(KDash);
    tap(KDot);
    chk("pending_overflow", 64'(pend), 64'd5);
    commit(6'd62, "overflow");
    chk("pending_after_overflow", 64'(pend), 64'd0);

    // Buzzer follows symbol keys in manual mode
    k_dash = 1'b0;
    #1 chk("buzzer_on", 64'(obuz), 64'd1);
    k_dash = 1'b1;
    #1 chk("buzzer_off", 64'(obuz), 64'd0);

    // Confirm and Dash in the same cycle: dash dropped
    tap(KDot);
    tap(KDot);
    k_conf = 1'b0;
    k_dash = 1'b0;
    expect_commit(6'd8);
    tick();
    k_conf = 1'b1;
    k_dash = 1'b1;
    tick();
    drain("same_cycle_I", 4);
    chk("pending_after_I", 64'(pend), 64'd0);

    // Backspace with symbols pending only discards them
    tap(KDot);
    tap(KDot);
    tap(KBack);
    chk("back_pending", 64'(pend), 64'd0);
    chk("back_pending_disp", 64'(disp), 64'(model_buf));

    // Mode change clears pending symbols
    tap(KDash);
    tap(KDash);
    mode = 1'b1;
    tick();
    chk("mode_change_clear", 64'(pend), 64'd0);

    // Timed mode: dot, dash, dot then idle gap -> R
    press_t(2);
    press_t(6);
    press_t(2);
    chk("timed_pending", 64'(pend), 64'd3);
    expect_commit(6'd17);
    drain("auto_R", 20);

    // Confirm during a press commits without the press (blank)
    k_dot = 1'b0;
    tick();
    tick();
    k_conf = 1'b0;
    expect_commit(6'd63);
    tick();
    k_conf = 1'b1;
    k_dot = 1'b1;
    tick();
    drain("press_confirm", 4);
    chk("press_confirm_pending", 64'(pend), 64'd0);

    // Manual: nine characters overflow the buffer, then backspace
    mode = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 1) begin
        tap(KDash);
        commit(6'd19, "fill_T");
      end else begin
        tap(KDot);
        commit(6'd4, "fill_E");
      end
    end
    chk("full_display", 64'(disp), 64'(model_buf));
    chk("newest_slot", 64'(disp[5:0]), 64'd4);
    tap(KBack);
    model_buf = {6'd63, model_buf[W-1:6]};
    chk("backspace_display", 64'(disp), 64'(model_buf));
    chk("backspace_top", 64'(disp[W-1:W-6]), 64'd63);

    // Key pressed while disabled gives no stale edge on re-enable
    en = 1'b0;
    k_dot = 1'b0;
    tick();
    tick();
    en = 1'b1;
    tick();
    tick();
    k_dot = 1'b1;
    tick();
    chk("enable_no_push", 64'(pend), 64'd0);

    // Reset in the middle of a timed gap
    mode = 1'b1;
    tick();
    press_t(2);
    tick();
    tick();
    chk("gap_pending", 64'(pend), 64'd1);
    rst_n = 1'b0;
    #1 chk_reset("reset_mid_gap");
    model_buf = '1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) tick();
    chk("final_scoreboard_empty", 64'(sb_q.size()), 64'd0);
    chk("final_display", 64'(disp), 64'(model_buf));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/morse_rx_decoder_gen.md
Name: morse_rx_decoder_gen

Overview:
Parametrised successor to the three-key Morse receive decoder. Builds each character from dots and dashes and decodes it into a 6-bit character code. Decoded characters shift into an NUM_CHARS-deep display buffer that drives the LCD/segment formatter. Adds a single-key timed mode (press length selects dot or dash; idle timeout commits the character), digit decoding (5-symbol codes), backspace, error/overflow reporting and a per-character strobe.

Parameters:
NUM_CHARS, 8, display buffer depth in characters (>=2)
DASH_TICKS, 6000000, timed mode: press held >= this many cycles is a dash, shorter is a dot
GAP_TICKS, 15000000, timed mode: release idle for this many cycles auto-commits the pending character
CNT_W, 24, press/gap counter width; must hold max(DASH_TICKS, GAP_TICKS)

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iEnable  in  1  block enable; when low, all state holds and no events are taken
iMode  in  1  0 = manual three-key, 1 = single-key timed (iKeyDot is the only symbol key)
iKeyDash  in  1  dash key, active low, pre-synchronised/debounced
iKeyDot  in  1  dot key (timed mode: the symbol key), active low
iKeyConfirm  in  1  commit key, active low
iKeyBack  in  1  backspace key, active low
oDisplayData  out  6*NUM_CHARS  buffer; newest char in bits [5:0]
oChar  out  6  last committed code
oCharValid  out  1  one-cycle pulse when oChar/oDisplayData update
oError  out  1  one-cycle pulse together with oCharValid when an error code (62) is committed
oPending  out  3  number of symbols in the current character (0..5)
oBuzzer  out  1  iEnable & (symbol key pressed)

Behaviour:
- Codes: A..Z = 0..25, digits 0..9 = 26..35, 62 = error, 63 = blank/off.
- Reset (async, iRST_N=0): every buffer slot = 63. stack=0, count=0, oChar=63. oCharValid=oError=0. Counters=0. FSM=IDLE. Key history = all released (1).
- Key history updates every cycle, even when iEnable=0. Re-enabling therefore never produces a stale edge. An event is a falling edge sampled while iEnable=1.
- Symbol push: stack = {stack[3:0], sym}, where dash=1 and dot=0; count+1. A push when count=5 sets the sticky overflow flag; stack and count hold.
- Decode at commit, from count and stack[count-1:0], first symbol in the MSB:
  - Standard letter table A..Z.
  - Digits: 11111=0, 01111=1, 00111=2, 00011=3, 00001=4, 00000=5, 10000=6, 11000=7, 11100=8, 11110=9.
  - Unlisted patterns, or overflow set -> 62.
  - count=0 -> 63 (inserts a space).
- Commit: buffer = {buffer[6*NUM_CHARS-7:0], code}. oChar=code. oCharValid=1 for one cycle, registered one cycle after the commit edge is sampled. oError=1 iff code=62. Then stack, count, overflow and counters clear. Oldest char falls off the top.
- Backspace:
  - If count>0: discard the pending symbols and overflow only. The buffer is unchanged and there is no strobe.
  - If count=0: buffer = {63, buffer[6*NUM_CHARS-1:6]}.
  - No strobe in either case.
- Same-cycle priority: Back > Confirm > Dash > Dot. Lower-priority edges in that cycle are dropped.
- Manual mode (iMode=0): a Dash edge pushes 1, a Dot edge pushes 0, a Confirm edge commits. The FSM stays in IDLE.
- Timed mode (iMode=1), FSM:
  - IDLE: on a Dot-key falling edge -> PRESS, press_cnt=1.
  - PRESS: press_cnt increments, saturating at DASH_TICKS. On release, push (press_cnt>=DASH_TICKS) and go to GAP with gap_cnt=0.
  - GAP: gap_cnt increments. A new press -> PRESS. When gap_cnt reaches GAP_TICKS-1 -> auto-commit and go to IDLE.
  - Confirm/Back act in any state. Confirm in PRESS commits without pushing the in-progress press and goes to IDLE. Back returns the FSM to IDLE.
  - iKeyDash is ignored.
- Changing iMode clears stack, count, overflow and counters and returns the FSM to IDLE. The buffer is kept.
- iEnable=0 mid-press: counters freeze; they resume when iEnable returns to 1.

Test Plan:
- Reset, then manual mode: Dot, Dash, Confirm -> oChar=0 (A), oCharValid pulse 1 cycle, oDisplayData[5:0]=0, all other slots 63.
- Manual mode: Dot, Dash×4, Confirm -> code 27 ('1'). Then Dash×5, Dot (overflow), Confirm -> code 62 with oError=1, and oPending reads 0 afterwards.
- Timed mode with DASH_TICKS=4, GAP_TICKS=8: presses of 2, 6 and 2 cycles, then idle 8 cycles -> auto-commit code 17 (R).
- Commit 9 characters with NUM_CHARS=8 -> the first character is lost, the newest is in [5:0]. Backspace at count=0 -> top slot becomes 63 and the others shift down by one slot.
- Same-cycle Confirm and Dash edges with count=2 (pattern 00) -> commits 8 (I); the dash is dropped.
- Hold Dot low, drop iEnable, release, raise iEnable -> no push, no commit. Assert iRST_N low mid-GAP -> all outputs return to their reset values immediately.
